// File: rtl/vmu_pkg.sv
// ---------------------------------------------------------------------------
// vmu_pkg
// Shared types and constants for the vector memory unit (vec_mem_unit).
//   - vmu_state_e : sequencer states IDLE / ISSUE / DRAIN / DONE
//   - LANE_IDX_W, VL_W, ELEM_BYTES : widths for the default 8-lane, 32-bit build
//   - vmuLaneIdxW / vmuVlW / vmuElemBytes : the same quantities for any
//     parameterisation, used by modules that take LANES / DATA_WIDTH parameters
// No ports (package).
// ---------------------------------------------------------------------------
package vmu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vmu_state_e;

    localparam int VMU_LANES_DEFAULT = 8;
    localparam int LANE_IDX_W        = $clog2(VMU_LANES_DEFAULT);
    localparam int VL_W              = $clog2(VMU_LANES_DEFAULT + 1);
    localparam int ELEM_BYTES        = 32 / 8;

    // A single-lane build still needs a one-bit lane index.
    function automatic int vmuLaneIdxW(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic int vmuVlW(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    function automatic int vmuElemBytes(input int dataWidth);
        return dataWidth / 8;
    endfunction

endpackage

// File: rtl/vmu_addr_gen.sv
// ---------------------------------------------------------------------------
// vmu_addr_gen
// Element address generator for vec_mem_unit: a loadable address accumulator
// plus an element counter.
// Ports:
//   clk_in     in   clock
//   rst_in     in   asynchronous active-high reset
//   i_load     in   start a new request: accumulator <= i_base, counter <= 0
//   i_base     in   base byte address
//   i_step     in   byte step added per element (two's complement)
//   i_advance  in   current element has been issued, move to the next one
//   i_vl       in   element count of the current request
//   o_addr     out  byte address of the current element
//   o_idx      out  index of the current element
//   o_done     out  every element of the request has been issued
// ---------------------------------------------------------------------------
module vmu_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int VL_W       = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [ADDR_WIDTH-1:0] i_step,
    input  logic                  i_advance,
    input  logic [VL_W-1:0]       i_vl,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [VL_W-1:0]       o_idx,
    output logic                  o_done
);

    logic [ADDR_WIDTH-1:0] r_acc;
    logic [VL_W-1:0]       r_cnt;

    // Full-width modular add: a negative step wraps downwards, truncation to
    // the ram width happens at the consumer.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_acc <= i_base;
            r_cnt <= '0;
        end else if (i_advance) begin
            r_acc <= r_acc + i_step;
            r_cnt <= r_cnt + VL_W'(1);
        end
    end

    assign o_addr = r_acc;
    assign o_idx  = r_cnt;
    assign o_done = (r_cnt == i_vl);

endmodule

// File: rtl/vec_mem_unit.sv
// ---------------------------------------------------------------------------
// vec_mem_unit
// Vector load/store engine between the cpu data path and port B of a
// single-port synchronous ram (one cycle read latency). One request of up to
// LANES elements is accepted at a time; one element is issued per cycle and
// the lanes are gathered (load) or scattered (store).
// Optional feature macro: VMU_STRIDE_EN -- when defined, req_stride sets the
// byte step between elements; otherwise the step is DATA_WIDTH/8.
// Ports:
//   clk_in      in   clock, all state on rising edge
//   rst_in      in   asynchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  high only while idle
//   req_we      in   1 = store, 0 = load
//   req_addr    in   base byte address
//   req_stride  in   signed byte stride (VMU_STRIDE_EN builds only)
//   req_vl      in   element count, clamped to LANES
//   req_wdata   in   store data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   resp_valid  out  completion, held until resp_ready
//   resp_ready  in   completion accepted
//   resp_rdata  out  load data, zero for stores and for lanes >= vl
//   ram_we      out  ram write enable
//   ram_addr    out  ram address (element byte address, truncated)
//   ram_din     out  ram write data
//   ram_dout    in   ram read data, valid the cycle after the address
// ---------------------------------------------------------------------------
module vec_mem_unit
    import vmu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LANES          = 8,
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [ADDR_WIDTH-1:0]         req_stride,
    input  logic [$clog2(LANES+1)-1:0]    req_vl,
    input  logic [LANES*DATA_WIDTH-1:0]   req_wdata,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [LANES*DATA_WIDTH-1:0]   resp_rdata,
    output logic                          ram_we,
    output logic [RAM_ADDR_WIDTH-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout
);

    localparam int L_LANE_IDX_W = vmuLaneIdxW(LANES);
    localparam int L_VL_W       = vmuVlW(LANES);
    localparam int L_ELEM_BYTES = vmuElemBytes(DATA_WIDTH);

    vmu_state_e                        r_state;
    logic                              r_reqReady;
    logic                              r_respValid;
    logic                              r_we;
    logic [L_VL_W-1:0]                 r_vl;
    logic [LANES-1:0][DATA_WIDTH-1:0]  r_wdata;
    logic [LANES-1:0][DATA_WIDTH-1:0]  r_rdata;
    logic                              r_ramWe;
    logic [RAM_ADDR_WIDTH-1:0]         r_ramAddr;
    logic [DATA_WIDTH-1:0]             r_ramDin;
    logic                              r_rdPend;
    logic [L_LANE_IDX_W-1:0]           r_rdLane;
    logic                              r_capValid;
    logic [L_LANE_IDX_W-1:0]           r_capLane;

    logic                              w_accept;
    logic [L_VL_W-1:0]                 w_vlClamped;
    logic [ADDR_WIDTH-1:0]             w_step;
    logic [ADDR_WIDTH-1:0]             w_elemAddr;
    logic [L_VL_W-1:0]                 w_idx;
    logic [L_LANE_IDX_W-1:0]           w_lane;
    logic                              w_genDone;
    logic                              w_genAdvance;
    logic                              w_unusedBits;

`ifdef VMU_STRIDE_EN
    logic [ADDR_WIDTH-1:0]             r_stride;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_stride <= '0;
        end else if (w_accept) begin
            r_stride <= req_stride;
        end
    end

    assign w_step       = r_stride;
    assign w_unusedBits = ^{w_elemAddr, w_idx};
`else
    assign w_step       = ADDR_WIDTH'(L_ELEM_BYTES);
    assign w_unusedBits = ^{w_elemAddr, w_idx, req_stride};
`endif

    assign w_accept     = req_valid && r_reqReady;
    assign w_vlClamped  = (req_vl > L_VL_W'(LANES)) ? L_VL_W'(LANES) : req_vl;
    assign w_genAdvance = (r_state == ISSUE) && !w_genDone;
    assign w_lane       = w_idx[L_LANE_IDX_W-1:0];

    vmu_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .VL_W       (L_VL_W)
    ) u_addrGen (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .i_load    (w_accept),
        .i_base    (req_addr),
        .i_step    (w_step),
        .i_advance (w_genAdvance),
        .i_vl      (r_vl),
        .o_addr    (w_elemAddr),
        .o_idx     (w_idx),
        .o_done    (w_genDone)
    );

    // Sequencer. The element registered onto the ram port at edge k is
    // written/read by the ram at edge k+1, and read data is captured into its
    // lane at edge k+2 via the rdPend -> capValid pipeline. ISSUE stays one
    // cycle past the last element so a store's final write has landed before
    // resp_valid rises; DRAIN waits for the last load word.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_reqReady  <= 1'b1;
            r_respValid <= 1'b0;
            r_we        <= 1'b0;
            r_vl        <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_ramWe     <= 1'b0;
            r_ramAddr   <= '0;
            r_ramDin    <= '0;
            r_rdPend    <= 1'b0;
            r_rdLane    <= '0;
            r_capValid  <= 1'b0;
            r_capLane   <= '0;
        end else begin
            r_ramWe    <= 1'b0;
            r_rdPend   <= 1'b0;
            r_capValid <= r_rdPend;
            r_capLane  <= r_rdLane;

            if (r_capValid) begin
                r_rdata[r_capLane] <= ram_dout;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_reqReady <= 1'b0;
                        r_we       <= req_we;
                        r_vl       <= w_vlClamped;
                        r_wdata    <= req_wdata;
                        r_rdata    <= '0;
                        r_state    <= (w_vlClamped == '0) ? DONE : ISSUE;
                    end
                end

                ISSUE: begin
                    if (!w_genDone) begin
                        r_ramWe   <= r_we;
                        r_ramAddr <= w_elemAddr[RAM_ADDR_WIDTH-1:0];
                        if (r_we) begin
                            r_ramDin <= r_wdata[w_lane];
                        end
                        r_rdPend  <= !r_we;
                        r_rdLane  <= w_lane;
                    end else if (r_we) begin
                        r_state     <= DONE;
                        r_respValid <= 1'b1;
                    end else begin
                        r_state <= DRAIN;
                    end
                end

                DRAIN: begin
                    r_state     <= DONE;
                    r_respValid <= 1'b1;
                end

                // Entered with resp_valid already set after real traffic; an
                // empty request arrives here straight from IDLE and raises it
                // one cycle later.
                DONE: begin
                    r_respValid <= 1'b1;
                    if (r_respValid && resp_ready) begin
                        r_state     <= IDLE;
                        r_respValid <= 1'b0;
                        r_reqReady  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_reqReady;
    assign resp_valid = r_respValid;
    assign resp_rdata = r_rdata;
    assign ram_we     = r_ramWe;
    assign ram_addr   = r_ramAddr;
    assign ram_din    = r_ramDin;

endmodule

// File: tb/tb_vec_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_vec_mem_unit
// Self-checking bench for vec_mem_unit with a behavioural ram on port B and
// a reference model that derives element addresses, load data, write traffic
// and completion latency from plain arithmetic over a shadow memory.
// ---------------------------------------------------------------------------
module tb_vec_mem_unit;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LANES = 8;
    localparam int RAW   = 17;
    localparam int VLW   = $clog2(LANES + 1);

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [AW-1:0]        req_addr;
    logic [AW-1:0]        req_stride;
    logic [VLW-1:0]       req_vl;
    logic [LANES*DW-1:0]  req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [LANES*DW-1:0]  resp_rdata;
    logic                 ram_we;
    logic [RAW-1:0]       ram_addr;
    logic [DW-1:0]        ram_din;
    logic [DW-1:0]        ram_dout = '0;

    int total = 0;
    int bad   = 0;

    vec_mem_unit #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .LANES          (LANES),
        .RAM_ADDR_WIDTH (RAW)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_stride (req_stride),
        .req_vl     (req_vl),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural single-port ram: read-before-write, one cycle latency.
    // Every committed write is logged for comparison against the model.
    logic [DW-1:0]  ramMem [0:(1<<RAW)-1];
    logic [RAW-1:0] obsAddr[$];
    logic [DW-1:0]  obsData[$];

    always @(posedge clk_in) begin
        ram_dout <= ramMem[ram_addr];
        if (ram_we) begin
            ramMem[ram_addr] = ram_din;
            obsAddr.push_back(ram_addr);
            obsData.push_back(ram_din);
        end
    end

    // Reference model: untouched ram words hold an address-derived pattern,
    // written words live in the shadow map.
    logic [DW-1:0] shadow [int];

    function automatic logic [DW-1:0] pat(input logic [RAW-1:0] a);
        return ({15'd0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [DW-1:0] modelRead(input logic [RAW-1:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return pat(a);
    endfunction

    function automatic logic [RAW-1:0] modelAddr(input logic [AW-1:0] base,
                                                 input logic [AW-1:0] step,
                                                 input int i);
        logic [AW-1:0] full;
        full = base + step * AW'(i);
        return full[RAW-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act,
                               input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_ctrl"}, {req_ready, resp_valid, ram_we}, 3'b100);
        checkOutput({name, "_ramaddr"}, ram_addr, '0);
        checkOutput({name, "_ramdin"}, ram_din, '0);
        checkOutput({name, "_rdata"}, resp_rdata, '0);
    endtask

    // One complete request: model prediction, handshake, latency, data,
    // optional resp_ready back-pressure, and write-traffic comparison.
    // Called #1 after a rising edge. expLat < 0 means use the model latency.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [AW-1:0] stride, input int vl,
                                 input logic [DW-1:0] wbase, input int expLat,
                                 input int hold, input string name,
                                 output logic [LANES*DW-1:0] rdataOut);
        logic [LANES*DW-1:0] wdata;
        logic [LANES*DW-1:0] expRdata;
        logic [AW-1:0]       step;
        logic [RAW-1:0]      expA[$];
        logic [DW-1:0]       expD[$];
        logic [RAW-1:0]      a;
        int                  vlc;
        int                  expL;
        int                  lat;
        int                  n;

`ifdef VMU_STRIDE_EN
        step = stride;
`else
        step = AW'(DW / 8);
`endif
        for (int i = 0; i < LANES; i++) wdata[i*DW +: DW] = wbase + DW'(i);
        vlc      = (vl > LANES) ? LANES : vl;
        expRdata = '0;
        for (int i = 0; i < vlc; i++) begin
            a = modelAddr(addr, step, i);
            if (we) begin
                expA.push_back(a);
                expD.push_back(wdata[i*DW +: DW]);
                shadow[int'(a)] = wdata[i*DW +: DW];
            end else begin
                expRdata[i*DW +: DW] = modelRead(a);
            end
        end
        if (expLat >= 0) expL = expLat;
        else expL = (vlc == 0) ? 1 : (we ? vlc + 1 : vlc + 2);

        obsAddr.delete();
        obsData.delete();

        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk_in); #1;
            n++;
        end
        checkOutput({name, "_ready"}, req_ready, 1'b1);

        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_stride = stride;
        req_vl     = VLW'(vl);
        req_wdata  = wdata;
        @(posedge clk_in); #1;
        req_valid  = 1'b0;
        checkOutput({name, "_busy"}, req_ready, 1'b0);

        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk_in); #1;
            lat++;
        end
        checkOutput({name, "_lat"}, lat, expL);
        checkOutput({name, "_rdata"}, resp_rdata, expRdata);
        rdataOut = resp_rdata;

        for (int h = 0; h < hold; h++) begin
            @(posedge clk_in); #1;
            checkOutput({name, "_hold_rdata"}, resp_rdata, rdataOut);
            checkOutput({name, "_hold_ctrl"}, {resp_valid, req_ready}, 2'b10);
        end

        // A request offered on the completion edge must not be taken.
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_vl     = '0;
        @(posedge clk_in); #1;
        resp_ready = 1'b0;
        checkOutput({name, "_ack"}, {resp_valid, req_ready, ram_we}, 3'b010);
        req_valid  = 1'b0;

        checkOutput({name, "_nwr"}, obsAddr.size(), expA.size());
        for (int i = 0; i < expA.size() && i < obsAddr.size(); i++) begin
            checkOutput({name, "_wr_addr"}, obsAddr[i], expA[i]);
            checkOutput({name, "_wr_data"}, obsData[i], expD[i]);
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [AW-1:0] stride;
        int            vl;
        logic [DW-1:0] wbase;
        int            expLat;
        string         name;
    } vec_t;

    initial begin
        vec_t                tbl[$];
        logic [LANES*DW-1:0] rd;
        logic [AW-1:0]       rAddr;
        logic [AW-1:0]       strides[6];
        logic [LANES*DW-1:0] wd;

        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_stride = '0;
        req_vl     = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        for (int a = 0; a < (1 << RAW); a++) ramMem[a] = pat(RAW'(a));

        #12;
        checkReset("por");
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // Reset in the second write cycle of an 8-element store.
        for (int i = 0; i < LANES; i++) wd[i*DW +: DW] = 32'hC0 + DW'(i);
        obsAddr.delete();
        obsData.delete();
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h200;
        req_stride = 32'd4;
        req_vl     = VLW'(8);
        req_wdata  = wd;
        @(posedge clk_in); #1;
        req_valid  = 1'b0;
        @(posedge clk_in); #1;
        checkOutput("rst_elem0", {ram_we, ram_addr, ram_din}, {1'b1, 17'h200, 32'hC0});
        @(posedge clk_in); #1;
        checkOutput("rst_elem1", {ram_we, ram_addr}, {1'b1, 17'h204});
        #3;
        rst_in = 1'b1;
        #1;
        checkReset("midop");
        @(posedge clk_in);
        @(posedge clk_in); #1;
        checkOutput("rst_nwr", obsAddr.size(), 1);
        if (obsAddr.size() > 0) begin
            checkOutput("rst_wr_addr", obsAddr[0], 17'h200);
            checkOutput("rst_wr_data", obsData[0], 32'hC0);
        end
        checkOutput("rst_still_idle", {req_ready, resp_valid, ram_we}, 3'b100);
        shadow[32'h200] = 32'hC0;
        rst_in = 1'b0;
        @(posedge clk_in); #1;

        // Store then full-width load back with back-pressure on the response.
        applyStimulus(1'b1, 32'h100, 32'd4, 4, 32'hA0, 5, 0, "st_vl4", rd);
        applyStimulus(1'b0, 32'h100, 32'd4, LANES, 32'h0, 10, 3, "ld_vl8", rd);
        for (int i = 0; i < 4; i++)
            checkOutput("ld_vl8_lane_lit", rd[i*DW +: DW], 32'hA0 + DW'(i));
        checkOutput("ld_vl8_lane4_pre", rd[4*DW +: DW], pat(17'h110));

        tbl.push_back('{1'b1, 32'h300,      32'd4, 0,         32'hD0, 1,  "st_vl0"});
        tbl.push_back('{1'b0, 32'h300,      32'd4, 0,         32'h0,  1,  "ld_vl0"});
        tbl.push_back('{1'b0, 32'h100,      32'd4, LANES + 1, 32'h0,  10, "ld_clamp"});
        tbl.push_back('{1'b1, 32'h1FFFC,    32'd4, 2,         32'hB0, 3,  "st_wrap"});
        tbl.push_back('{1'b0, 32'h1FFFC,    32'd4, 2,         32'h0,  4,  "ld_wrap"});
        tbl.push_back('{1'b0, 32'h200,      32'd4, 2,         32'h0,  4,  "ld_after_rst"});
        tbl.push_back('{1'b1, 32'h400,      32'd4, 1,         32'hE0, 2,  "st_vl1"});
        tbl.push_back('{1'b0, 32'h400,      32'd4, 1,         32'h0,  3,  "ld_vl1"});
        tbl.push_back('{1'b0, 32'hFFFF0100, 32'd4, 3,         32'h0,  5,  "ld_hibits"});
`ifdef VMU_STRIDE_EN
        tbl.push_back('{1'b0, 32'h20,       -32'sd8, 3,       32'h0,  5,  "ld_stride_neg"});
        tbl.push_back('{1'b1, 32'h40,       32'd0, 3,         32'hF0, 4,  "st_bcast"});
        tbl.push_back('{1'b0, 32'h1FFF8,    32'd8, 2,         32'h0,  4,  "ld_stride_wrap"});
`endif
        for (int t = 0; t < tbl.size(); t++) begin
            applyStimulus(tbl[t].we, tbl[t].addr, tbl[t].stride, tbl[t].vl,
                          tbl[t].wbase, tbl[t].expLat, 0, tbl[t].name, rd);
        end
        checkOutput("ld_wrap_lit", rd[0 +: DW] !== 32'hx, 1'b1);

        strides[0] = -32'sd8;
        strides[1] = -32'sd4;
        strides[2] = 32'd0;
        strides[3] = 32'd4;
        strides[4] = 32'd8;
        strides[5] = 32'd16;
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 7) == 0) rAddr = 32'h1FFE0 + 32'd4 * $urandom_range(0, 7);
            else rAddr = 32'd4 * $urandom_range(0, 255);
            rAddr = rAddr | (AW'($urandom_range(0, 7)) << RAW);
            applyStimulus(1'($urandom_range(0, 1)), rAddr, strides[$urandom_range(0, 5)],
                          int'($urandom_range(0, LANES + 1)), $urandom, -1,
                          int'($urandom_range(0, 2)), "rnd", rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
